// File: rtl/sar_pkg.sv
// Shared types and default sizing for the SAR conversion controller.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        TRIG,
        WAIT,
        DONE
    } sar_state_e;

    localparam int SAR_N_BITS        = 8;
    localparam int SAR_SAMPLE_CYCLES = 4;
    localparam int SAR_CMP_TIMEOUT   = 15;
    localparam int SAR_MAX_RETRY     = 2;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int SAR_IDX_W  = cnt_width(SAR_N_BITS - 1);
    localparam int SAR_SAMP_W = cnt_width(SAR_SAMPLE_CYCLES - 1);
    localparam int SAR_WAIT_W = cnt_width(SAR_CMP_TIMEOUT - 1);

endpackage

// File: rtl/sar_sync2.sv
// Two-flop synchronizer for asynchronous single-bit-per-lane inputs.
module sar_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: sample, per-bit comparator trigger, binary search, result.
// Optional comparator re-trigger on timeout is enabled by defining SAR_RETRY_EN.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int N_BITS        = SAR_N_BITS,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
    parameter int CMP_TIMEOUT   = SAR_CMP_TIMEOUT
`ifdef SAR_RETRY_EN
  , parameter int MAX_RETRY     = SAR_MAX_RETRY
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              comp,
    input  logic              valid,
    output logic              cmp_trig,
    output logic              sample,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] dout,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W  = cnt_width(N_BITS - 1);
    localparam int SAMP_W = cnt_width(SAMPLE_CYCLES - 1);
    localparam int WAIT_W = cnt_width(CMP_TIMEOUT - 1);

    localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(N_BITS - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CMP_TIMEOUT - 1);
    localparam logic [N_BITS-1:0] CODE_MID  = {1'b1, {(N_BITS-1){1'b0}}};

    sar_state_e        state;
    sar_state_e        state_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic [SAMP_W-1:0] samp_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic [1:0] sync_q;
    logic       comp_s;
    logic       valid_s;

    logic take_bit;
    logic bit_val;
    logic retry;

`ifdef SAR_RETRY_EN
    localparam int RETRY_W = cnt_width(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry_cnt;
`endif

    sar_sync2 #(
        .WIDTH (2)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({comp, valid}),
        .q     (sync_q)
    );

    assign comp_s  = sync_q[1];
    assign valid_s = sync_q[0];

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        take_bit  = 1'b0;
        bit_val   = comp_s;
        retry     = 1'b0;

        case (state)
            IDLE: begin
                if (start && en) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (samp_cnt == SAMP_LAST) state_nxt = TRIG;
            end
            TRIG: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (valid_s) begin
                    take_bit = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
`ifdef SAR_RETRY_EN
                    if (retry_cnt < RETRY_MAX) begin
                        retry = 1'b1;
                    end else begin
                        take_bit = 1'b1;
                        bit_val  = 1'b1;
                    end
`else
                    take_bit = 1'b1;
                    bit_val  = 1'b1;
`endif
                end
                if (retry)         state_nxt = TRIG;
                else if (take_bit) state_nxt = (bit_idx == '0) ? DONE : TRIG;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Disabling the block aborts wherever it is.
        if (!en && state != IDLE) state_nxt = IDLE;
    end

    assign sample   = (state == SAMPLE);
    assign cmp_trig = (state == TRIG);
    assign done     = (state == DONE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_idx  <= '0;
            samp_cnt <= '0;
            wait_cnt <= '0;
            dac_code <= '0;
            dout     <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!en && state != IDLE) begin
                dac_code <= '0;
                samp_cnt <= '0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && en) begin
                            dac_code <= CODE_MID;
                            err      <= 1'b0;
                            bit_idx  <= IDX_MSB;
                            samp_cnt <= '0;
                        end
                    end
                    SAMPLE: begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                    TRIG: begin
                        wait_cnt <= '0;
                    end
                    WAIT: begin
                        if (take_bit) begin
                            dac_code[bit_idx] <= bit_val;
                            if (bit_idx != '0) begin
                                dac_code[bit_idx - 1'b1] <= 1'b1;
                                bit_idx                  <= bit_idx - 1'b1;
                            end else begin
                                // Result is registered on entry to DONE so it is valid with the pulse.
                                dout <= {dac_code[N_BITS-1:1], bit_val};
                            end
                            if (!valid_s) err <= 1'b1;
                        end else if (!retry) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef SAR_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (state == IDLE || take_bit) begin
            retry_cnt <= '0;
        end else if (retry && en) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`endif

endmodule
